// File: rtl/multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_fsm
//   Main control unit of the multicycle RISC core. Sequences fetch, decode,
//   execute, memory and writeback over several cycles, drives the register
//   write enables and the select lines of the shared datapath muxes, and runs
//   the ready/timeout handshake with the unified memory port.
//
// Parameters
//   MEM_TIMEOUT  max wait cycles for memReady per memory access (>=1)
//   CNT_W        width of the retired-instruction counter
//
// Optional feature (macro RETIRE_CNT_EN)
//   When defined, adds output instrRetired [CNT_W-1:0], a wrapping count of
//   completed instructions. When undefined the port and counter are absent.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   synchronous reset, active-low
//   instrType    in   decoded class: 0 R-ALU,1 I-ALU,2 LW,3 SW,4 BEQ,5 JMP,
//                     6 HALT,7 illegal
//   zeroFlag     in   ALU zero result (BEQ compare)
//   memReady     in   memory completes current access this cycle
//   memRead      out  memory read request
//   memWrite     out  memory write request
//   addrSel      out  memory address: 0 PC, 1 ALUOut
//   irWrite      out  load instruction register
//   pcWrite      out  load PC
//   pcSrcSel     out  next PC: 00 PC+1, 01 branch target, 10 jump target
//   aluSrcASel   out  ALU A: 0 PC, 1 regA
//   aluSrcBSel   out  ALU B: 00 regB, 01 const 1, 10 imm, 11 branch offset
//   wbSel        out  writeback: 00 ALUOut, 01 MDR, 10 PC, 11 zero
//   regWrite     out  register file write enable
//   halted       out  core stopped
//   errCode      out  00 none, 01 illegal opcode, 10 memory timeout
//   instrRetired out  retired-instruction count (RETIRE_CNT_EN only)
// ---------------------------------------------------------------------------
module multicycle_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       instrType,
  input  logic             zeroFlag,
  input  logic             memReady,
  output logic             memRead,
  output logic             memWrite,
  output logic             addrSel,
  output logic             irWrite,
  output logic             pcWrite,
  output logic [1:0]       pcSrcSel,
  output logic             aluSrcASel,
  output logic [1:0]       aluSrcBSel,
  output logic [1:0]       wbSel,
  output logic             regWrite,
  output logic             halted,
  output logic [1:0]       errCode
`ifdef RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0] instrRetired
`endif
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  localparam logic [2:0] CLS_IALU = 3'd1;
  localparam logic [2:0] CLS_LW   = 3'd2;
  localparam logic [2:0] CLS_JMP  = 3'd5;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEMADDR,
    S_MEMRD, S_MEMWR, S_WB, S_BRANCH, S_HALT
  } state_t;

  state_t            state, state_next;
  logic [2:0]        class_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic [1:0]        err_q, err_next;
  logic              mem_state;
  logic              wait_at_limit;

  assign mem_state     = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign wait_at_limit = (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
  assign errCode       = err_q;

  // State, latched instruction class, wait counter and sticky error code.
  // The wait counter restarts whenever the state changes, so every memory
  // access gets its own full timeout budget.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      class_q  <= 3'd0;
      wait_cnt <= '0;
      err_q    <= ERR_NONE;
    end else begin
      state <= state_next;
      err_q <= err_next;
      if (state == S_DECODE) class_q <= instrType;
      if (state_next != state) wait_cnt <= '0;
      else if (mem_state && !memReady) wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Next-state and Moore output decode. A memReady arriving in the same
  // cycle as the timeout limit completes the access rather than halting.
  always_comb begin
    state_next = state;
    err_next   = err_q;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    addrSel    = 1'b0;
    irWrite    = 1'b0;
    pcWrite    = 1'b0;
    pcSrcSel   = 2'b00;
    aluSrcASel = 1'b0;
    aluSrcBSel = 2'b00;
    wbSel      = 2'b00;
    regWrite   = 1'b0;
    halted     = 1'b0;

    case (state)
      S_IDLE: state_next = S_FETCH;

      S_FETCH: begin
        memRead = 1'b1;
        if (memReady) begin
          irWrite    = 1'b1;
          pcWrite    = 1'b1;
          aluSrcBSel = 2'b01;
          state_next = S_DECODE;
        end else if (wait_at_limit) begin
          state_next = S_HALT;
          err_next   = ERR_TIMEOUT;
        end
      end

      S_DECODE: begin
        // Branch target is precomputed here so BRANCH only needs the compare.
        aluSrcBSel = 2'b11;
        case (instrType)
          3'd0, 3'd1: state_next = S_EXEC;
          3'd2, 3'd3: state_next = S_MEMADDR;
          3'd4:       state_next = S_BRANCH;
          3'd5: begin
            pcWrite    = 1'b1;
            pcSrcSel   = 2'b10;
            state_next = S_FETCH;
          end
          3'd6:       state_next = S_HALT;
          default: begin
            state_next = S_HALT;
            err_next   = ERR_ILLEGAL;
          end
        endcase
      end

      S_EXEC: begin
        aluSrcASel = 1'b1;
        aluSrcBSel = (class_q == CLS_IALU) ? 2'b10 : 2'b00;
        state_next = S_WB;
      end

      S_MEMADDR: begin
        aluSrcASel = 1'b1;
        aluSrcBSel = 2'b10;
        state_next = (class_q == CLS_LW) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        memRead = 1'b1;
        addrSel = 1'b1;
        if (memReady) begin
          state_next = S_WB;
        end else if (wait_at_limit) begin
          state_next = S_HALT;
          err_next   = ERR_TIMEOUT;
        end
      end

      S_MEMWR: begin
        memWrite = 1'b1;
        addrSel  = 1'b1;
        if (memReady) begin
          state_next = S_FETCH;
        end else if (wait_at_limit) begin
          state_next = S_HALT;
          err_next   = ERR_TIMEOUT;
        end
      end

      S_WB: begin
        regWrite   = 1'b1;
        wbSel      = (class_q == CLS_LW) ? 2'b01 : 2'b00;
        state_next = S_FETCH;
      end

      S_BRANCH: begin
        aluSrcASel = 1'b1;
        aluSrcBSel = 2'b00;
        if (zeroFlag) begin
          pcWrite  = 1'b1;
          pcSrcSel = 2'b01;
        end
        state_next = S_FETCH;
      end

      S_HALT: halted = 1'b1;

      default: state_next = S_IDLE;
    endcase
  end

`ifdef RETIRE_CNT_EN
  logic retire;

  // An instruction retires on the cycle it leaves its final state; halts,
  // illegal opcodes and timeouts never reach one of these exits.
  always_comb begin
    retire = (state == S_WB) || (state == S_BRANCH) ||
             ((state == S_MEMWR) && memReady) ||
             ((state == S_DECODE) && (instrType == CLS_JMP));
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!rst_n) instrRetired <= '0;
    else if (retire) instrRetired <= instrRetired + 1'b1;
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl_fsm
//   Self-checking bench for multicycle_ctrl_fsm. Each instruction is expanded
//   into a per-cycle timeline of expected outputs (from its class, its memory
//   delays and the branch flag); the timeline drives the inputs and every
//   cycle's outputs are compared. Build with RETIRE_CNT_EN defined to also
//   check the retired-instruction counter.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl_fsm;

  localparam int MEM_TIMEOUT = 16;
  localparam int CNT_W       = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] instrType = 3'd0;
  logic       zeroFlag = 1'b0;
  logic       memReady = 1'b0;
  logic       memRead, memWrite, addrSel, irWrite, pcWrite;
  logic [1:0] pcSrcSel;
  logic       aluSrcASel;
  logic [1:0] aluSrcBSel, wbSel;
  logic       regWrite, halted;
  logic [1:0] errCode;
`ifdef RETIRE_CNT_EN
  logic [CNT_W-1:0] instrRetired;
`endif

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .instrType(instrType), .zeroFlag(zeroFlag),
    .memReady(memReady), .memRead(memRead), .memWrite(memWrite),
    .addrSel(addrSel), .irWrite(irWrite), .pcWrite(pcWrite),
    .pcSrcSel(pcSrcSel), .aluSrcASel(aluSrcASel), .aluSrcBSel(aluSrcBSel),
    .wbSel(wbSel), .regWrite(regWrite), .halted(halted), .errCode(errCode)
`ifdef RETIRE_CNT_EN
    , .instrRetired(instrRetired)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       memRead;
    logic       memWrite;
    logic       addrSel;
    logic       irWrite;
    logic       pcWrite;
    logic [1:0] pcSrcSel;
    logic       aluSrcASel;
    logic [1:0] aluSrcBSel;
    logic [1:0] wbSel;
    logic       regWrite;
    logic       halted;
    logic [1:0] errCode;
  } outs_t;

  typedef struct {
    logic [2:0] instr;
    logic       zero;
    logic       ready;
    outs_t      exp;
    string      tag;
  } step_t;

  step_t            sched[$];
  int               compared = 0;
  int               mismatched = 0;
  logic [CNT_W-1:0] retiredModel = '0;

  function automatic logic [2:0] rnd3();
    return 3'($urandom_range(0, 7));
  endfunction

  function automatic logic rnd1();
    return 1'($urandom_range(0, 1));
  endfunction

  // Mostly short delays, occasionally the exact limit or a full timeout.
  function automatic int pickDelay();
    int r;
    r = $urandom_range(0, 29);
    if (r == 0) return MEM_TIMEOUT;
    if (r == 1) return MEM_TIMEOUT - 1;
    return $urandom_range(0, 3);
  endfunction

  task automatic applyStimulus(input logic [2:0] instr, input logic zero, input logic ready);
    instrType = instr;
    zeroFlag  = zero;
    memReady  = ready;
  endtask

  task automatic checkOutput(input outs_t exp, input string tag);
    outs_t obs;
    obs = {memRead, memWrite, addrSel, irWrite, pcWrite, pcSrcSel, aluSrcASel,
           aluSrcBSel, wbSel, regWrite, halted, errCode};
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%05h expected=%05h", tag, obs, exp);
    end
  endtask

  task automatic checkCount(input string tag);
`ifdef RETIRE_CNT_EN
    compared++;
    assert (instrRetired === retiredModel) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, instrRetired, retiredModel);
    end
`else
    if (tag.len() < 0) $display("[TB] %s", tag);
`endif
  endtask

  task automatic push(input logic [2:0] instr, input logic zero, input logic ready,
                      input outs_t e, input string tag);
    step_t s;
    s.instr = instr;
    s.zero  = zero;
    s.ready = ready;
    s.exp   = e;
    s.tag   = tag;
    sched.push_back(s);
  endtask

  // One memory access (0 fetch, 1 read, 2 write) answered after d idle cycles;
  // d at or beyond MEM_TIMEOUT means memory never answers in time.
  task automatic addAccess(input int kind, input int d, output bit timedOut);
    outs_t e;
    bit    rdy;
    int    n;
    timedOut = (d >= MEM_TIMEOUT);
    n = timedOut ? MEM_TIMEOUT : d + 1;
    for (int k = 0; k < n; k++) begin
      rdy = !timedOut && (k == d);
      e = '0;
      if (kind == 0) begin
        e.memRead = 1'b1;
        if (rdy) begin
          e.irWrite    = 1'b1;
          e.pcWrite    = 1'b1;
          e.aluSrcBSel = 2'b01;
        end
      end else if (kind == 1) begin
        e.memRead = 1'b1;
        e.addrSel = 1'b1;
      end else begin
        e.memWrite = 1'b1;
        e.addrSel  = 1'b1;
      end
      push(rnd3(), rnd1(), rdy, e, (kind == 0) ? "fetch" : (kind == 1) ? "memrd" : "memwr");
    end
  endtask

  task automatic addHalt(input logic [1:0] err, input int cycles);
    outs_t e;
    e = '0;
    e.halted  = 1'b1;
    e.errCode = err;
    for (int k = 0; k < cycles; k++) push(rnd3(), rnd1(), rnd1(), e, "halt");
  endtask

  task automatic buildInstr(input logic [2:0] cls, input int dF, input int dM, input logic zf,
                            output bit halts, output bit retires);
    bit    to;
    outs_t e;
    halts = 1'b0;
    retires = 1'b0;
    addAccess(0, dF, to);
    if (to) begin
      addHalt(2'b10, 3);
      halts = 1'b1;
      return;
    end
    e = '0;
    e.aluSrcBSel = 2'b11;
    if (cls == 3'd5) begin
      e.pcWrite  = 1'b1;
      e.pcSrcSel = 2'b10;
    end
    push(cls, rnd1(), rnd1(), e, "decode");
    case (cls)
      3'd0, 3'd1: begin
        e = '0;
        e.aluSrcASel = 1'b1;
        e.aluSrcBSel = (cls == 3'd1) ? 2'b10 : 2'b00;
        push(rnd3(), rnd1(), rnd1(), e, "exec");
        e = '0;
        e.regWrite = 1'b1;
        push(rnd3(), rnd1(), rnd1(), e, "wb_alu");
        retires = 1'b1;
      end
      3'd2, 3'd3: begin
        e = '0;
        e.aluSrcASel = 1'b1;
        e.aluSrcBSel = 2'b10;
        push(rnd3(), rnd1(), rnd1(), e, "memaddr");
        addAccess((cls == 3'd2) ? 1 : 2, dM, to);
        if (to) begin
          addHalt(2'b10, 3);
          halts = 1'b1;
        end else begin
          if (cls == 3'd2) begin
            e = '0;
            e.regWrite = 1'b1;
            e.wbSel    = 2'b01;
            push(rnd3(), rnd1(), rnd1(), e, "wb_lw");
          end
          retires = 1'b1;
        end
      end
      3'd4: begin
        e = '0;
        e.aluSrcASel = 1'b1;
        if (zf) begin
          e.pcWrite  = 1'b1;
          e.pcSrcSel = 2'b01;
        end
        push(rnd3(), zf, rnd1(), e, "branch");
        retires = 1'b1;
      end
      3'd5: retires = 1'b1;
      3'd6: begin
        addHalt(2'b00, 3);
        halts = 1'b1;
      end
      default: begin
        addHalt(2'b01, 3);
        halts = 1'b1;
      end
    endcase
  endtask

  task automatic runSched();
    step_t s;
    while (sched.size() > 0) begin
      s = sched.pop_front();
      applyStimulus(s.instr, s.zero, s.ready);
      #1;
      checkOutput(s.exp, s.tag);
      @(posedge clk);
      #1;
    end
  endtask

  // Finishes with reset low and the DUT in IDLE, then releases it; on return
  // the DUT has just entered FETCH.
  task automatic finishReset(input string tag);
    checkOutput('0, tag);
    retiredModel = '0;
    checkCount("count_after_reset");
    rst_n = 1'b1;
    applyStimulus(rnd3(), rnd1(), rnd1());
    #1;
    checkOutput('0, "idle_release");
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    repeat (3) begin
      applyStimulus(rnd3(), rnd1(), rnd1());
      @(posedge clk);
      #1;
    end
    finishReset("reset_idle");
  endtask

  task automatic runInstr(input logic [2:0] cls, input int dF, input int dM, input logic zf);
    bit halts, retires;
    buildInstr(cls, dF, dM, zf, halts, retires);
    runSched();
    if (retires) retiredModel = retiredModel + 1'b1;
    checkCount("retired");
    if (halts) doReset();
  endtask

  initial begin : main
    bit    to;
    outs_t e;
    int    r;
    logic [2:0] cls;

    doReset();

    runInstr(3'd0, 0, 0, 1'b0);
    runInstr(3'd2, 0, 3, 1'b0);
    runInstr(3'd4, 0, 0, 1'b1);
    runInstr(3'd4, 1, 0, 1'b0);
    runInstr(3'd5, 2, 0, 1'b0);
    runInstr(3'd3, 0, 2, 1'b0);
    runInstr(3'd1, 0, 0, 1'b0);
    runInstr(3'd2, MEM_TIMEOUT - 1, 0, 1'b0);
    runInstr(3'd3, 0, MEM_TIMEOUT - 1, 1'b0);
    runInstr(3'd7, 0, 0, 1'b0);
    runInstr(3'd0, MEM_TIMEOUT, 0, 1'b0);
    runInstr(3'd0, 0, 0, 1'b0);
    runInstr(3'd2, 0, MEM_TIMEOUT, 1'b0);
    runInstr(3'd6, 0, 0, 1'b0);

    // Reset in the middle of a stalled load.
    runInstr(3'd1, 0, 0, 1'b0);
    addAccess(0, 0, to);
    e = '0;
    e.aluSrcBSel = 2'b11;
    push(3'd2, 1'b0, 1'b0, e, "decode");
    e = '0;
    e.aluSrcASel = 1'b1;
    e.aluSrcBSel = 2'b10;
    push(rnd3(), 1'b0, 1'b0, e, "memaddr");
    e = '0;
    e.memRead = 1'b1;
    e.addrSel = 1'b1;
    push(rnd3(), 1'b0, 1'b0, e, "memrd_wait");
    push(rnd3(), 1'b0, 1'b0, e, "memrd_wait");
    runSched();
    rst_n = 1'b0;
    applyStimulus(3'd2, 1'b0, 1'b0);
    #1;
    checkOutput(e, "memrd_at_reset");
    @(posedge clk);
    #1;
    finishReset("reset_midaccess");

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0) cls = 3'd6;
      else if (r == 1) cls = 3'd7;
      else cls = 3'($urandom_range(0, 5));
      runInstr(cls, pickDelay(), pickDelay(), rnd1());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
